// File: rtl/div_ctrl.sv
// Multi-cycle signed 32-bit restoring divider controller.
// It sequences a shared external adder/subtractor through the sign fix-up and iteration steps.
module div_ctrl (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic [31:0] as_in1,
    output logic [31:0] as_in2,
    output logic        as_sub,
    input  logic [31:0] as_result,
    input  logic        as_ovf,
    output logic        busy,
    output logic        ready,
    output logic [31:0] quotient,
    output logic [31:0] remainder,
    output logic        div_by_zero
);

    typedef enum logic [2:0] {
        IDLE,
        NEG_A,
        NEG_B,
        ITER,
        FIX_Q,
        FIX_R,
        DONE,
        DZ
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] a_reg;
    logic [31:0] b_reg;
    logic [31:0] r_reg;
    logic [31:0] q_reg;
    logic [4:0]  cnt;
    logic        sa;
    logic        sb;
    logic [31:0] rs;
    logic [31:0] qs;
    logic        borrow;
    logic        unused_ovf;

    assign unused_ovf = as_ovf;

    assign rs     = {r_reg[30:0], q_reg[31]};
    assign qs     = {q_reg[30:0], 1'b0};
    // Unsigned borrow of rs - b_reg without a 33rd adder bit.
    assign borrow = (~rs[31] & b_reg[31]) | (~(rs[31] ^ b_reg[31]) & as_result[31]);

    assign busy  = (state != IDLE);
    assign ready = (state == DONE) || (state == DZ);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        as_in1     = 32'd0;
        as_in2     = 32'd0;
        as_sub     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (divisor == 32'd0) ? DZ : NEG_A;
                end
            end
            NEG_A: begin
                as_in2     = a_reg;
                as_sub     = 1'b1;
                state_next = NEG_B;
            end
            NEG_B: begin
                as_in2     = b_reg;
                as_sub     = 1'b1;
                state_next = ITER;
            end
            ITER: begin
                as_in1 = rs;
                as_in2 = b_reg;
                as_sub = 1'b1;
                if (cnt == 5'd0) begin
                    state_next = FIX_Q;
                end
            end
            FIX_Q: begin
                as_in2     = q_reg;
                as_sub     = 1'b1;
                state_next = FIX_R;
            end
            FIX_R: begin
                as_in2     = r_reg;
                as_sub     = 1'b1;
                state_next = DONE;
            end
            DONE:    state_next = IDLE;
            DZ:      state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_reg       <= 32'd0;
            b_reg       <= 32'd0;
            r_reg       <= 32'd0;
            q_reg       <= 32'd0;
            cnt         <= 5'd0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            quotient    <= 32'd0;
            remainder   <= 32'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg <= dividend;
                        b_reg <= divisor;
                        sa    <= dividend[31];
                        sb    <= divisor[31];
                        // Divide-by-zero results must already be visible in the DZ cycle.
                        if (divisor == 32'd0) begin
                            quotient    <= 32'd0;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end else begin
                            div_by_zero <= 1'b0;
                        end
                    end
                end
                NEG_A: begin
                    a_reg <= sa ? as_result : a_reg;
                    r_reg <= 32'd0;
                end
                NEG_B: begin
                    b_reg <= sb ? as_result : b_reg;
                    cnt   <= 5'd31;
                    q_reg <= a_reg;
                end
                ITER: begin
                    if (!borrow) begin
                        r_reg <= as_result;
                        q_reg <= qs | 32'd1;
                    end else begin
                        r_reg <= rs;
                        q_reg <= qs;
                    end
                    cnt <= cnt - 5'd1;
                end
                FIX_Q: quotient  <= (sa ^ sb) ? as_result : q_reg;
                FIX_R: remainder <= sa ? as_result : r_reg;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard bench for div_ctrl: stimulus pushes expected results, a monitor checks every ready pulse.
module tb_div_ctrl;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          due;
    } exp_t;

    logic        clock;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] as_in1;
    logic [31:0] as_in2;
    logic        as_sub;
    logic [31:0] as_result;
    logic        as_ovf;
    logic        busy;
    logic        ready;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_by_zero;

    int   cycle;
    int   checks;
    int   failures;
    exp_t sb[$];

    div_ctrl dut (
        .clock       (clock),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .as_in1      (as_in1),
        .as_in2      (as_in2),
        .as_sub      (as_sub),
        .as_result   (as_result),
        .as_ovf      (as_ovf),
        .busy        (busy),
        .ready       (ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Behavioural model of the shared adder/subtractor.
    always_comb begin
        as_result = as_sub ? (as_in1 - as_in2) : (as_in1 + as_in2);
        as_ovf    = as_sub ? ((as_in1[31] != as_in2[31]) && (as_result[31] != as_in1[31]))
                           : ((as_in1[31] == as_in2[31]) && (as_result[31] != as_in1[31]));
    end

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every ready pulse must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (!reset && ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("[TB] FAIL unexpected_ready actual=1 expected=0 at cycle %0d", cycle);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("quotient", quotient, e.q);
                checkOutput("remainder", remainder, e.r);
                checkOutput("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
                checkOutput("ready_cycle", cycle, e.due);
                checkOutput("busy_at_ready", {31'd0, busy}, 32'd1);
            end
        end
    end

    task automatic startRaw(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] q, input logic [31:0] r, input logic dz);
        exp_t e;
        @(negedge clock);
        checkOutput("busy_before_start", {31'd0, busy}, 32'd0);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        e.q   = q;
        e.r   = r;
        e.dz  = dz;
        e.due = cycle + (dz ? 1 : 37);
        sb.push_back(e);
        @(negedge clock);
        start    = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain_timeout actual=%0d expected=0 pending results", sb.size());
            sb.delete();
        end
        @(negedge clock);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clock);
    endtask

    initial begin
        cycle    = 0;
        checks   = 0;
        failures = 0;
        reset    = 1'b1;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        idleCycles(3);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        checkOutput("reset_ready", {31'd0, ready}, 32'd0);
        checkOutput("reset_quotient", quotient, 32'd0);
        checkOutput("reset_remainder", remainder, 32'd0);
        checkOutput("reset_dz", {31'd0, div_by_zero}, 32'd0);
        checkOutput("reset_as_in2", as_in2, 32'd0);
        checkOutput("reset_as_sub", {31'd0, as_sub}, 32'd0);
        reset = 1'b0;
        idleCycles(2);

        // 7 / 2 with busy tracked across T+1..T+37, then a start in the ready cycle that must be ignored.
        applyStimulus(32'd7, 32'd2, 32'd3, 32'd1, 1'b0);
        checkOutput("busy_T1", {31'd0, busy}, 32'd1);
        for (int i = 2; i <= 37; i++) begin
            @(negedge clock);
            if (busy !== 1'b1) checkOutput($sformatf("busy_T%0d", i), {31'd0, busy}, 32'd1);
        end
        checkOutput("ready_T37", {31'd0, ready}, 32'd1);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        checkOutput("busy_after_ready", {31'd0, busy}, 32'd0);
        idleCycles(42);

        applyStimulus(32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0);
        waitDrain();
        applyStimulus(32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 32'd1, 1'b0);
        waitDrain();
        applyStimulus(32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 1'b0);
        waitDrain();
        applyStimulus(32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        waitDrain();
        applyStimulus(32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 1'b0);
        waitDrain();
        applyStimulus(32'h7FFF_FFFF, 32'd1, 32'h7FFF_FFFF, 32'd0, 1'b0);
        waitDrain();

        applyStimulus(32'd12, 32'd0, 32'd0, 32'd12, 1'b1);
        waitDrain();
        checkOutput("dz_held", {31'd0, div_by_zero}, 32'd1);
        applyStimulus(32'd12, 32'd4, 32'd3, 32'd0, 1'b0);
        waitDrain();

        // A second start mid-division must not produce a second ready.
        applyStimulus(32'd50, 32'd5, 32'd10, 32'd0, 1'b0);
        idleCycles(8);
        dividend = 32'd100;
        divisor  = 32'd7;
        start    = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        waitDrain();
        idleCycles(40);

        // Reset during a division aborts it silently.
        startRaw(32'd50, 32'd5);
        idleCycles(8);
        reset = 1'b1;
        @(negedge clock);
        checkOutput("abort_busy", {31'd0, busy}, 32'd0);
        checkOutput("abort_ready", {31'd0, ready}, 32'd0);
        checkOutput("abort_quotient", quotient, 32'd0);
        checkOutput("abort_remainder", remainder, 32'd0);
        reset = 1'b0;
        idleCycles(40);
        applyStimulus(32'd9, 32'd3, 32'd3, 32'd0, 1'b0);
        waitDrain();
        idleCycles(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
